// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared width default, opcode and FSM state types for alu_ctrl.
package alu_ctrl_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_MUL  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - sequences an external accumulator ALU through LOAD/ADD/MUL with repeat count.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         InstrValid,
  output logic         InstrReady,
  input  logic [1:0]   Opcode,
  input  logic [n-1:0] Operand,
  input  logic [3:0]   Rep,
  input  logic [n-1:0] AluResult,
  output logic [n-1:0] DataA,
  output logic [n-1:0] DataB,
  output logic         WriteEn,
  output logic         UseMul,
  output logic         ResultValid,
  input  logic         ResultReady,
  output logic [n-1:0] ResultData,
  output logic         Busy
);

  state_t         state, state_nxt;
  opcode_t        op_q;
  logic [n-1:0]   operand_q;
  logic [3:0]     cnt, cnt_nxt;
  logic           capture;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= OP_NOP;
      operand_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        op_q      <= opcode_t'(Opcode);
        operand_q <= Operand;
      end
    end
  end

  // Outputs decode purely from state so reset removes WriteEn without waiting for a clock.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    capture     = 1'b0;
    InstrReady  = 1'b0;
    WriteEn     = 1'b0;
    UseMul      = 1'b0;
    DataA       = AluResult;
    DataB       = '0;
    ResultValid = 1'b0;
    Busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) begin
          capture   = 1'b1;
          cnt_nxt   = Rep;
          state_nxt = (opcode_t'(Opcode) == OP_NOP) ? ST_DONE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        Busy    = 1'b1;
        WriteEn = 1'b1;
        DataB   = operand_q;
        UseMul  = (op_q == OP_MUL);
        if (op_q == OP_LOAD) DataA = '0;
        // Counter stops at zero on the final write edge, so Rep=15 never wraps.
        if (cnt == 4'd0) state_nxt = ST_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_DONE: begin
        Busy        = 1'b1;
        ResultValid = 1'b1;
        if (ResultReady) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ResultData = AluResult;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - alu_ctrl looped with a Q1.7 accumulator ALU model, scoreboarded results.
module tb_alu_ctrl;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, ADD = 2'b10, MUL = 2'b11;

  logic       clk, nReset;
  logic       InstrValid, InstrReady;
  logic [1:0] Opcode;
  logic [7:0] Operand;
  logic [3:0] Rep;
  logic [7:0] AluResult, DataA, DataB, ResultData;
  logic       WriteEn, UseMul, ResultValid, ResultReady, Busy;

  int total = 0;
  int bad   = 0;
  int we_cnt  = 0;
  int mul_cnt = 0;
  logic [7:0] exp_q[$];

  alu_ctrl #(.n(8)) dut (
    .clk(clk), .nReset(nReset),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .Operand(Operand), .Rep(Rep),
    .AluResult(AluResult), .DataA(DataA), .DataB(DataB),
    .WriteEn(WriteEn), .UseMul(UseMul),
    .ResultValid(ResultValid), .ResultReady(ResultReady),
    .ResultData(ResultData), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] q17_mul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[14:7];
  endfunction

  // Accumulator ALU beside the controller
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)      AluResult <= '0;
    else if (WriteEn) AluResult <= UseMul ? q17_mul(DataA, DataB) : DataA + DataB;
  end

  always @(negedge clk) begin
    if (WriteEn) we_cnt  <= we_cnt + 1;
    if (UseMul)  mul_cnt <= mul_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [7:0] val, input logic [3:0] rep,
                           input logic [7:0] exp_res, input int exp_we, input int exp_mul,
                           input int exp_lat, input int hold);
    int we0, mul0, lat;
    logic [7:0] e;
    check_eq("instr_ready_idle", {31'd0, InstrReady}, 32'd1);
    we0 = we_cnt; mul0 = mul_cnt;
    InstrValid = 1'b1; Opcode = op; Operand = val; Rep = rep;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1 InstrValid = 1'b0; Opcode = LOAD; Operand = 8'hA5; Rep = 4'hF;
    @(negedge clk);
    lat = 0;
    while (!ResultValid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("we_count", we_cnt - we0, exp_we);
    check_eq("mul_count", mul_cnt - mul0, exp_mul);
    for (int i = 0; i < hold; i++) begin
      InstrValid = 1'b1; Opcode = LOAD; Operand = 8'h99; Rep = 4'd0;
      @(negedge clk);
      check_eq("hold_valid", {31'd0, ResultValid}, 32'd1);
      check_eq("hold_ready", {31'd0, InstrReady}, 32'd0);
      check_eq("hold_we", {31'd0, WriteEn}, 32'd0);
      check_eq("hold_busy", {31'd0, Busy}, 32'd1);
    end
    InstrValid = 1'b0;
    ResultReady = 1'b1;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("result_data", {24'd0, ResultData}, {24'd0, e});
    end
    @(negedge clk);
    ResultReady = 1'b0;
    check_eq("back_idle", {30'd0, InstrReady, Busy}, 32'd2);
  endtask

  initial begin
    int we0, stray;
    nReset = 1'b0; InstrValid = 1'b0; Opcode = NOP; Operand = '0; Rep = '0; ResultReady = 1'b0;
    #1;
    check_eq("rst_state", {26'd0, InstrReady, WriteEn, UseMul, ResultValid, Busy, |DataB},
             32'b100000);
    @(negedge clk); @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);

    run_instr(LOAD, 8'h10, 4'd0,  8'h10, 1, 0, 1, 0);
    run_instr(LOAD, 8'h10, 4'd0,  8'h10, 1, 0, 1, 0);
    run_instr(ADD,  8'h05, 4'd2,  8'h1F, 3, 0, 3, 0);
    run_instr(LOAD, 8'h40, 4'd0,  8'h40, 1, 0, 1, 0);
    run_instr(MUL,  8'h40, 4'd1,  8'h10, 2, 2, 2, 0);
    run_instr(LOAD, 8'h22, 4'd0,  8'h22, 1, 0, 1, 0);
    run_instr(NOP,  8'h77, 4'd3,  8'h22, 0, 0, 0, 5);
    run_instr(LOAD, 8'h7F, 4'd0,  8'h7F, 1, 0, 1, 0);
    run_instr(ADD,  8'h01, 4'd0,  8'h80, 1, 0, 1, 0);
    run_instr(LOAD, 8'h00, 4'd0,  8'h00, 1, 0, 1, 0);
    run_instr(ADD,  8'h01, 4'd15, 8'h10, 16, 0, 16, 0);

    // Abort a long ADD with an asynchronous reset in the middle of a cycle
    we0 = we_cnt;
    InstrValid = 1'b1; Opcode = ADD; Operand = 8'h01; Rep = 4'd15;
    exp_q.push_back(8'h20);
    @(posedge clk);
    #1 InstrValid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("abort_pre_we", {31'd0, WriteEn}, 32'd1);
    #2 nReset = 1'b0;
    #1;
    check_eq("abort_we", {31'd0, WriteEn}, 32'd0);
    check_eq("abort_flags", {29'd0, Busy, ResultValid, UseMul}, 32'd0);
    void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    #1;
    check_eq("abort_ready", {31'd0, InstrReady}, 32'd1);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ResultValid || WriteEn || Busy) stray++;
    end
    check_eq("abort_quiet", stray, 0);
    check_eq("abort_we_total", we_cnt - we0, 4);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: n, 8, ALU operand/result width in bits (Q1.7 fixed point for multiply).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nReset  input  1  reset, asynchronous and active-low.
REQ-004 InstrValid  input  1  instruction offered this cycle.
REQ-005 InstrReady  output  1  controller can accept an instruction (high only in IDLE).
REQ-006 Opcode  input  2  00 NOP, 01 LOAD, 10 ADD, 11 MUL.
REQ-007 Operand  input  n  immediate, driven to ALU DataB.
REQ-008 Rep  input  4  repeat count; operation applied Rep+1 times.
REQ-009 AluResult  input  n  ALU accumulator output (registered inside ALU).
REQ-010 DataA  output  n  ALU first operand.
REQ-011 DataB  output  n  ALU second operand.
REQ-012 WriteEn  output  1  ALU accumulator write strobe.
REQ-013 UseMul  output  1  select ALU multiply (1) or add (0).
REQ-014 ResultValid  output  1  ResultData holds the completed instruction's result.
REQ-015 ResultReady  input  1  consumer accepts the result.
REQ-016 ResultData  output  n  equals AluResult while ResultValid is high.
REQ-017 Busy  output  1  high in EXEC or DONE.

Function
REQ-018 FSM states IDLE, EXEC, DONE.
REQ-019 IDLE: InstrReady=1; on InstrValid&&InstrReady the block SHALL register Opcode, Operand, Rep (iteration counter = Rep).
REQ-020 IDLE accept with Opcode NOP SHALL go directly to DONE with no WriteEn pulse.
REQ-021 IDLE accept with LOAD/ADD/MUL SHALL go to EXEC.
REQ-022 EXEC: WriteEn=1 every cycle; counter decrements each edge; at counter==0 edge go to DONE; exactly Rep+1 WriteEn cycles.
REQ-023 EXEC LOAD: DataA=0, DataB=Operand, UseMul=0 (ALU result := Operand).
REQ-024 EXEC ADD: DataA=AluResult, DataB=Operand, UseMul=0.
REQ-025 EXEC MUL: DataA=AluResult, DataB=Operand, UseMul=1.
REQ-026 Outside EXEC: WriteEn=0, UseMul=0, DataA=AluResult, DataB=0.
REQ-027 DONE: ResultValid=1, ResultData=AluResult; stay in DONE while ResultReady=0; ResultReady=1 -> IDLE next edge.
REQ-028 InstrValid during EXEC/DONE SHALL be ignored (InstrReady=0; no capture).
REQ-029 ResultReady outside DONE SHALL be ignored.
REQ-030 Latency: ResultValid rises after Rep+1 edges following the accepting edge (NOP: the accepting edge itself).
REQ-031 Rep=15 SHALL give 16 writes; counter SHALL not wrap or underflow.
REQ-032 Overflow/saturation behaviour belongs to the ALU; controller SHALL not modify data.

Reset
REQ-033 nReset low SHALL immediately force IDLE, counter 0, registered instruction 0, WriteEn=0, UseMul=0, ResultValid=0, Busy=0, InstrReady=1 (after release).
REQ-034 Reset during EXEC SHALL abort the instruction with no further WriteEn pulses and no ResultValid.

Structure
REQ-035 Shared package alu_ctrl_pkg SHALL hold width n default, opcode enum (NOP/LOAD/ADD/MUL) and FSM state enum.
REQ-036 Single module, no sub-module; ALU is instantiated beside it, not inside it.

Verification
REQ-037 Bench SHALL loop alu_ctrl with the team ALU (AluResult <- ALU result) and cover:
REQ-038 LOAD 0x10 Rep=0 -> one WriteEn cycle, ResultValid after 1 edge, ResultData=0x10.
REQ-039 LOAD 0x10, then ADD 0x05 Rep=2 -> three WriteEn cycles, ResultData=0x1F.
REQ-040 LOAD 0x40, then MUL 0x40 Rep=1 -> ResultData=0x10 (0.5^3=0.125).
REQ-041 NOP after LOAD 0x22 -> no WriteEn, ResultValid on accept edge, ResultData=0x22; ResultReady held low 5 cycles -> ResultValid stays, InstrValid ignored.
REQ-042 ADD 0x01 Rep=15 with nReset pulsed low mid-EXEC -> WriteEn drops asynchronously, no ResultValid, IDLE with InstrReady=1 after release.
